// File: rtl/rubik_group_sched_if.sv
// Handshake/status bundle between software-side control, datapath and the
// RUBIK group scheduler. slave = scheduler side, master = driver side.
interface rubik_group_sched_if #(
   parameter int CNT_W = 16
);
   logic             producer;
   logic             op_en_wr;
   logic             op_en_wdata;
   logic             dp_done;
   logic             consumer;
   logic [1:0]       status_0;
   logic [1:0]       status_1;
   logic             op_en_0;
   logic             op_en_1;
   logic             dp_start;
   logic             dp_grp;
   logic [1:0]       done_intr;
   logic [CNT_W-1:0] layer_cnt;

   modport slave (
      input  producer, op_en_wr, op_en_wdata, dp_done,
      output consumer, status_0, status_1, op_en_0, op_en_1,
      output dp_start, dp_grp, done_intr, layer_cnt
   );

   modport master (
      output producer, op_en_wr, op_en_wdata, dp_done,
      input  consumer, status_0, status_1, op_en_0, op_en_1,
      input  dp_start, dp_grp, done_intr, layer_cnt
   );
endinterface

// File: rtl/rubik_group_sched.sv
// Ping-pong register-group scheduler: per-group OP_ENABLE, consumer pointer,
// datapath launch/retire, per-group status and done interrupt pulses.
// Ports: nvdla_core_clk, nvdla_core_rstn (async active-low), bus (slave):
//   in  producer/op_en_wr/op_en_wdata/dp_done
//   out consumer/status_0/status_1/op_en_0/op_en_1/dp_start/dp_grp/
//       done_intr/layer_cnt
// Macro NVDLA_RBK_LAYER_CNT_EN: when defined, layer_cnt counts retires;
// otherwise layer_cnt is tied to 0 and no counter flops exist.
module rubik_group_sched #(
   parameter int SWITCH_GAP = 2,
   parameter int CNT_W      = 16
) (
   input logic               nvdla_core_clk,
   input logic               nvdla_core_rstn,
   rubik_group_sched_if.slave bus
);

   typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, DRAIN} state_e;

   localparam logic [3:0] GAP = 4'(SWITCH_GAP);

   state_e     state_q, state_d;
   logic       cons_q, cons_d;
   logic [1:0] op_en_q, op_en_d;
   logic [3:0] gap_q, gap_d;
   logic [1:0] done_q, done_d;
   logic       start_q, start_d;
   logic       active;

   assign active = (state_q == LAUNCH) || (state_q == BUSY);

   always_comb begin
      state_d = state_q;
      cons_d  = cons_q;
      op_en_d = op_en_q;
      gap_d   = gap_q;
      done_d  = 2'b00;

      // Software write first, so a same-edge retire overrides a set.
      if (bus.op_en_wr) begin
         if (bus.op_en_wdata)
            op_en_d[bus.producer] = 1'b1;
         else if (!(bus.producer == cons_q && active))
            op_en_d[bus.producer] = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if (op_en_q[cons_q]) state_d = LAUNCH;
         end
         LAUNCH: begin
            state_d = BUSY;
         end
         BUSY: begin
            if (bus.dp_done) begin
               op_en_d[cons_q] = 1'b0;
               done_d[cons_q]  = 1'b1;
               cons_d          = ~cons_q;
               gap_d           = GAP;
               state_d         = (SWITCH_GAP == 0) ? IDLE : DRAIN;
            end
         end
         DRAIN: begin
            gap_d = gap_q - 4'd1;
            if (gap_q <= 4'd1) state_d = IDLE;
         end
      endcase

      start_d = (state_d == LAUNCH);
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         state_q <= IDLE;
         cons_q  <= 1'b0;
         op_en_q <= 2'b00;
         gap_q   <= 4'd0;
         done_q  <= 2'b00;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cons_q  <= cons_d;
         op_en_q <= op_en_d;
         gap_q   <= gap_d;
         done_q  <= done_d;
         start_q <= start_d;
      end
   end

`ifdef NVDLA_RBK_LAYER_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn)
         cnt_q <= '0;
      else if (state_q == BUSY && bus.dp_done)
         cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   assign bus.layer_cnt = cnt_q;
`else
   assign bus.layer_cnt = {CNT_W{1'b0}};
`endif

   // Running only while the group owns the datapath; otherwise pending.
   always_comb begin
      bus.status_0 = 2'd0;
      bus.status_1 = 2'd0;
      if (op_en_q[0])
         bus.status_0 = (!cons_q && active) ? 2'd1 : 2'd2;
      if (op_en_q[1])
         bus.status_1 = (cons_q && active) ? 2'd1 : 2'd2;
   end

   assign bus.consumer  = cons_q;
   assign bus.dp_grp    = cons_q;
   assign bus.op_en_0   = op_en_q[0];
   assign bus.op_en_1   = op_en_q[1];
   assign bus.dp_start  = start_q;
   assign bus.done_intr = done_q;

endmodule

// File: tb/tb_rubik_group_sched.sv
// Self-checking bench for rubik_group_sched: scoreboard queues hold the
// expected dp_start and done_intr events, a negedge monitor pops them.
module tb_rubik_group_sched;

   localparam int GAP = 2;
   localparam int CW  = 16;

   typedef struct {
      int         cyc;
      logic [1:0] val;
   } ev_t;

   logic clk;
   logic rstn;
   int   cyc;
   int   total;
   int   bad;
   ev_t  st_q[$];
   ev_t  dn_q[$];

   rubik_group_sched_if #(.CNT_W(CW)) bus ();

   rubik_group_sched #(
      .SWITCH_GAP (GAP),
      .CNT_W      (CW)
   ) dut (
      .nvdla_core_clk  (clk),
      .nvdla_core_rstn (rstn),
      .bus             (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)",
                  tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic g, input logic d);
      bus.producer    = g;
      bus.op_en_wdata = d;
      bus.op_en_wr    = 1'b1;
      step();
      bus.op_en_wr    = 1'b0;
   endtask

   task automatic done_wr(input logic w, input logic g, input logic d);
      bus.producer    = g;
      bus.op_en_wdata = d;
      bus.op_en_wr    = w;
      bus.dp_done     = 1'b1;
      step();
      bus.dp_done     = 1'b0;
      bus.op_en_wr    = 1'b0;
   endtask

   function automatic void exp_start(input int c, input logic g);
      ev_t e;
      e.cyc = c;
      e.val = {1'b0, g};
      st_q.push_back(e);
   endfunction

   function automatic void exp_done(input int c, input logic [1:0] v);
      ev_t e;
      e.cyc = c;
      e.val = v;
      dn_q.push_back(e);
   endfunction

   always @(negedge clk) begin : mon
      ev_t e;
      if (bus.dp_start) begin
         if (st_q.size() == 0) begin
            chk("start_extra", 32'(bus.dp_start), 0);
         end else begin
            e = st_q.pop_front();
            chk("start_cyc", cyc, e.cyc);
            chk("start_grp", 32'(bus.dp_grp), 32'(e.val[0]));
         end
      end
      if (bus.done_intr != 2'b00) begin
         if (dn_q.size() == 0) begin
            chk("done_extra", 32'(bus.done_intr), 0);
         end else begin
            e = dn_q.pop_front();
            chk("done_cyc", cyc, e.cyc);
            chk("done_val", 32'(bus.done_intr), 32'(e.val));
         end
      end
   end

   task automatic chk_rst(input string tag);
      chk({tag, "_cons"}, 32'(bus.consumer), 0);
      chk({tag, "_st0"}, 32'(bus.status_0), 0);
      chk({tag, "_st1"}, 32'(bus.status_1), 0);
      chk({tag, "_en0"}, 32'(bus.op_en_0), 0);
      chk({tag, "_en1"}, 32'(bus.op_en_1), 0);
      chk({tag, "_start"}, 32'(bus.dp_start), 0);
      chk({tag, "_intr"}, 32'(bus.done_intr), 0);
      chk({tag, "_cnt"}, 32'(bus.layer_cnt), 0);
   endtask

   int cnt_exp;

   initial begin
      total           = 0;
      bad             = 0;
      rstn            = 1'b0;
      bus.producer    = 1'b0;
      bus.op_en_wr    = 1'b0;
      bus.op_en_wdata = 1'b0;
      bus.dp_done     = 1'b0;

      // reset state
      repeat (3) step();
      chk_rst("rst");
      rstn = 1'b1;
      while (cyc < 9) step();

      // single group 0 layer
      exp_start(cyc + 2, 1'b0);
      wr(1'b0, 1'b1);
      chk("en0_set", 32'(bus.op_en_0), 1);
      chk("st0_pend", 32'(bus.status_0), 2);
      step();
      chk("st0_run", 32'(bus.status_0), 1);
      chk("st1_idle", 32'(bus.status_1), 0);
      step();
      chk("st0_busy", 32'(bus.status_0), 1);
      exp_done(cyc + 1, 2'b01);
      done_wr(1'b0, 1'b0, 1'b0);
      chk("ret_cons", 32'(bus.consumer), 1);
      chk("ret_st0", 32'(bus.status_0), 0);
      chk("ret_en0", 32'(bus.op_en_0), 0);
      repeat (GAP + 1) step();

      // fresh start, both groups, alternate 0 then 1
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      step();
      chk_rst("rst2");
      wr(1'b1, 1'b1);
      chk("en1_pend", 32'(bus.status_1), 2);
      exp_start(cyc + 2, 1'b0);
      wr(1'b0, 1'b1);
      step();
      step();
      chk("pp_st0", 32'(bus.status_0), 1);
      chk("pp_st1", 32'(bus.status_1), 2);
      exp_done(cyc + 1, 2'b01);
      exp_start(cyc + 1 + GAP + 1, 1'b1);
      done_wr(1'b0, 1'b0, 1'b0);
      chk("pp_cons1", 32'(bus.consumer), 1);
      chk("pp_st1_drain", 32'(bus.status_1), 2);
      repeat (GAP + 1) step();
      step();
      chk("pp_st1_run", 32'(bus.status_1), 1);
      chk("pp_st0_off", 32'(bus.status_0), 0);
      exp_done(cyc + 1, 2'b10);
      done_wr(1'b0, 1'b0, 1'b0);
      chk("pp_cons0", 32'(bus.consumer), 0);
`ifdef NVDLA_RBK_LAYER_CNT_EN
      cnt_exp = 2;
`else
      cnt_exp = 0;
`endif
      chk("layer_cnt", 32'(bus.layer_cnt), cnt_exp);
      repeat (GAP + 1) step();

      // clear pending vs running, simultaneous writes with retire
      wr(1'b1, 1'b1);
      exp_start(cyc + 2, 1'b0);
      wr(1'b0, 1'b1);
      step();
      step();
      wr(1'b1, 1'b0);
      chk("clr_en1", 32'(bus.op_en_1), 0);
      chk("clr_st1", 32'(bus.status_1), 0);
      wr(1'b0, 1'b0);
      chk("noclr_en0", 32'(bus.op_en_0), 1);
      chk("noclr_st0", 32'(bus.status_0), 1);
      exp_done(cyc + 1, 2'b01);
      exp_start(cyc + 1 + GAP + 1, 1'b1);
      done_wr(1'b1, 1'b1, 1'b1);
      chk("both_en1", 32'(bus.op_en_1), 1);
      chk("both_en0", 32'(bus.op_en_0), 0);
      chk("both_cons", 32'(bus.consumer), 1);
      repeat (GAP + 1) step();
      step();
      exp_done(cyc + 1, 2'b10);
      done_wr(1'b1, 1'b1, 1'b1);
      chk("win_en1", 32'(bus.op_en_1), 0);
      chk("win_st1", 32'(bus.status_1), 0);
      chk("win_cons", 32'(bus.consumer), 0);
      repeat (GAP + 2) step();

      // dp_done outside BUSY
      done_wr(1'b0, 1'b0, 1'b0);
      chk("idle_done_cons", 32'(bus.consumer), 0);
      exp_start(cyc + 2, 1'b0);
      wr(1'b0, 1'b1);
      step();
      done_wr(1'b0, 1'b0, 1'b0);
      chk("lau_done_cons", 32'(bus.consumer), 0);
      chk("lau_done_en0", 32'(bus.op_en_0), 1);
      chk("lau_done_st0", 32'(bus.status_0), 1);

      // reset while BUSY
      rstn = 1'b0;
      #2;
      chk_rst("rst_busy");
      step();
      rstn = 1'b1;
      step();
      exp_start(cyc + 2, 1'b0);
      wr(1'b0, 1'b1);
      step();
      step();
      exp_done(cyc + 1, 2'b01);
      done_wr(1'b0, 1'b0, 1'b0);
      chk("re_cons", 32'(bus.consumer), 1);
      repeat (GAP + 2) step();

      chk("start_left", st_q.size(), 0);
      chk("done_left", dn_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
